inst_fetch_unit: RTL and testbench

- Consumer of the program counter: reads the current PC value, fetches the 16-bit instruction word from instruction memory over a req/ack handshake, then pulses the PC advance strobe.
- Buffers fetched words with their PC in a small FIFO and presents them to the decoder over valid/ready.
- Handles control-flow redirects: on flush, discards buffered and in-flight instructions while the PC loads its branch target.

---
 rtl/ifu_pkg.sv | 19 +
 rtl/ifu_fifo.sv | 56 +++++
 rtl/inst_fetch_unit.sv | 120 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default address/data widths and the FIFO entry width helper.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } ifu_state_e;

  localparam int IFU_AW = 16;
  localparam int IFU_DW = 16;

  // A buffered entry carries {pc, instruction word}.
  function automatic int entry_width(input int aw, input int dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO: power-of-two depth, synchronous clear that beats push/pop,
// head word visible combinationally (zero while empty).
module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok, pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge Clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push_ok && !pop_ok)      count_reg <= count_reg + CW'(1);
      else if (pop_ok && !push_ok) count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC -> memory req/ack -> prefetch FIFO -> decoder.
// Define IFU_PERF_CNT_EN to add the perf_fetched / perf_stall counters.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = IFU_AW,
  parameter int DW    = IFU_DW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] PCResult,
  output logic          PCWrite,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  input  logic          flush,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_data,
  output logic [AW-1:0] instr_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]   perf_fetched,
  output logic [15:0]   perf_stall
`endif
);

  localparam int EW = entry_width(AW, DW);
  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e    state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [CW-1:0] fifo_count, count_after;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [EW-1:0] fifo_dout;

  assign push        = (state_reg == REQ) && mem_ack && !flush;
  assign pop         = instr_valid && instr_ready && !flush;
  assign count_after = fifo_count + CW'(1) - CW'(pop);
  assign PCWrite     = push;
  assign mem_req     = (state_reg != IDLE);
  assign mem_addr    = addr_reg;
  assign instr_valid = !fifo_empty;
  assign instr_pc    = fifo_dout[EW-1:DW];
  assign instr_data  = fifo_dout[DW-1:0];

  ifu_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   ({addr_reg, mem_rdata}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    unique case (state_reg)
      IDLE: begin
        if (!flush && !fifo_full) begin
          state_next = REQ;
          addr_next  = PCResult;
        end
      end
      REQ: begin
        if (flush) begin
          state_next = mem_ack ? IDLE : DRAIN;
        end else if (mem_ack) begin
          if (count_after < CW'(DEPTH)) begin
            // PCWrite advances the PC on this same edge, so take the value it will hold.
            state_next = REQ;
            addr_next  = PCResult + AW'(1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef IFU_PERF_CNT_EN
  logic [15:0] fetched_reg, stall_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetched_reg <= '0;
      stall_reg   <= '0;
    end else begin
      if (pop && fetched_reg != 16'hFFFF) fetched_reg <= fetched_reg + 16'd1;
      if (!instr_valid && instr_ready && stall_reg != 16'hFFFF) stall_reg <= stall_reg + 16'd1;
    end
  end

  assign perf_fetched = fetched_reg;
  assign perf_stall   = stall_reg;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: owns the PC and memory, predicts the
// decoder-visible stream with a queue model and checks it every cycle.
module tb_inst_fetch_unit;

  localparam int DEPTH = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] PCResult;
  logic        PCWrite;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_stall;
`endif

  inst_fetch_unit #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PCResult    (PCResult),
    .PCWrite     (PCWrite),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .flush       (flush),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        q[$];
  logic [15:0] pc_m;
  bit          req_active, req_killed, prev_idle_ok;
  int          wait_cnt;
  logic [15:0] req_addr;
  int          lat_lo = 1, lat_hi = 1;
  int          n_pops = 0, n_issued = 0;
  int          exp_fetched = 0, exp_stall = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // One clock cycle: drive inputs after the falling edge, check, then apply
  // the architectural effect of the coming rising edge to the model.
  task automatic run_cycle(input int flush_pct, input int ready_pct,
                           input bit flush_on_ack, input logic [15:0] target);
    bit ack_now, exp_pw, pop_now;
    @(negedge Clk);
    if (prev_idle_ok) chk("issue_when_not_full", mem_req, 1);
    if (mem_req && !req_active) begin
      req_active = 1;
      req_killed = 0;
      req_addr   = mem_addr;
      wait_cnt   = $urandom_range(lat_hi, lat_lo);
      n_issued++;
      chk("req_addr", mem_addr, pc_m);
      chk("req_not_full", q.size() < DEPTH, 1);
    end else if (req_active) begin
      chk("req_held", mem_req, 1);
      chk("addr_stable", mem_addr, req_addr);
    end
    ack_now = req_active && (wait_cnt == 0);
    if (req_active && !ack_now) wait_cnt--;
    mem_ack     = ack_now;
    mem_rdata   = ack_now ? word(req_addr) : 16'($urandom);
    flush       = flush_on_ack ? ack_now : ($urandom_range(99, 0) < flush_pct);
    instr_ready = ($urandom_range(99, 0) < ready_pct);
    PCResult    = pc_m;
    #1;
    exp_pw  = ack_now && !req_killed && !flush;
    pop_now = (q.size() != 0) && instr_ready && !flush;
    chk("pcwrite", PCWrite, exp_pw);
    chk("instr_valid", instr_valid, q.size() != 0);
    if (pop_now) begin
      chk("head_pc", instr_pc, q[0].pc);
      chk("head_data", instr_data, q[0].data);
      $display("pop pc=%h data=%h", instr_pc, instr_data);
    end
    if (pop_now && exp_fetched < 65535) exp_fetched++;
    if (q.size() == 0 && instr_ready && exp_stall < 65535) exp_stall++;
    prev_idle_ok = !mem_req && !flush && (q.size() < DEPTH);
    if (flush) begin
      q.delete();
      pc_m = target;
      if (req_active && !ack_now) req_killed = 1;
    end else begin
      if (pop_now) void'(q.pop_front());
      if (exp_pw) begin
        q.push_back('{pc: req_addr, data: word(req_addr)});
        pc_m = pc_m + 16'd1;
      end
    end
    if (ack_now) req_active = 0;
    if (pop_now) n_pops++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_pcwrite"}, PCWrite, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_data"}, instr_data, 0);
    chk({tag, "_pc"}, instr_pc, 0);
    chk({tag, "_addr"}, mem_addr, 0);
  endtask

  initial begin
    Reset = 0; PCResult = 0; mem_ack = 0; mem_rdata = 0; flush = 0; instr_ready = 0;
    pc_m = 0; req_active = 0; req_killed = 0; prev_idle_ok = 0; wait_cnt = 0; req_addr = 0;
    repeat (2) @(negedge Clk);
    #1 check_reset_outputs("rst");
    @(negedge Clk);
    Reset = 1;
    prev_idle_ok = 1;

    // Streaming fetch with single-cycle memory latency.
    for (int i = 0; i < 16; i++) run_cycle(0, 100, 0, 16'h0);

    // Stalled decoder: FIFO fills, requests stop, then resume.
    for (int i = 0; i < 12; i++) run_cycle(0, 0, 0, 16'h0);
    chk("full_no_req", mem_req, 0);
    chk("full_valid", instr_valid, 1);
    for (int i = 0; i < 8; i++) run_cycle(0, 100, 0, 16'h0);

    // Flush while a slow request is outstanding.
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && !(req_active && wait_cnt == 2); i++) run_cycle(0, 100, 0, 16'h0);
    chk("flush_setup", req_active, 1);
    run_cycle(100, 100, 0, 16'h0040);
    for (int i = 0; i < 12; i++) run_cycle(0, 100, 0, 16'h0);

    // Flush coinciding with the ack that would fill the FIFO.
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20 && !(q.size() == DEPTH - 1 && req_active); i++) run_cycle(0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 1, 16'h0100);
    for (int i = 0; i < 8; i++) run_cycle(0, 100, 0, 16'h0);

    // Reset mid-request; the stale ack lands right after release.
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && !(req_active && wait_cnt > 0); i++) run_cycle(0, 100, 0, 16'h0);
    chk("reset_setup", req_active, 1);
    @(negedge Clk);
    Reset = 0; mem_ack = 0; flush = 0;
    #1 check_reset_outputs("midrst");
    q.delete();
    exp_fetched = 0; exp_stall = 0;
    repeat (2) @(negedge Clk);
    Reset = 1; mem_ack = 1; mem_rdata = 16'hDEAD; instr_ready = 1; PCResult = pc_m;
    #1;
    chk("stale_ack_pcwrite", PCWrite, 0);
    chk("stale_ack_valid", instr_valid, 0);
    exp_stall++;
    req_active = 0;
    prev_idle_ok = 1;
    for (int i = 0; i < 4; i++) run_cycle(0, 100, 0, 16'h0);

    // Random traffic, including redirects near the top of the address space.
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 3000; i++)
      run_cycle(4, 60, 0, ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom));

    chk("progress", n_pops > 300, 1);
`ifdef IFU_PERF_CNT_EN
    #1;
    chk("perf_fetched", perf_fetched, exp_fetched);
    chk("perf_stall", perf_stall, exp_stall);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
